orth_dds: RTL and testbench

Quadrature direct digital synthesizer: a phase accumulator driven by a signed frequency control word plus a signed phase offset addresses a quarter-wave sine table. It produces phase-locked sine and cosine samples as signed fixed-point words. It is the local-oscillator source of the down-conversion chain, feeding mixers and FIR filters running on the same clock.

---
 rtl/orth_dds.sv | 91 +++++++++
 tb/tb_orth_dds.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/orth_dds.sv
// Quadrature DDS: accumulator plus phase offset addresses a quarter-wave sine table
// built at elaboration; sin/cos appear three enabled edges after the phase sum.
module orth_dds #(
  parameter int FREQ_DW = 32,
  parameter int LC_DW   = 12,
  parameter int PAW     = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [FREQ_DW-1:0]      freq,
  input  logic [FREQ_DW-1:0]      phase,
  output logic signed [LC_DW-1:0] sin,
  output logic signed [LC_DW-1:0] cos
);
  localparam int N   = 2 ** (PAW - 2);
  localparam int QW  = PAW - 2;
  localparam int MW  = LC_DW - 1;
  localparam int AMP = 2 ** (LC_DW - 1) - 1;
  localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

  // Fixed-point (Q60) Taylor series keeps the table bit-exact to a real-valued reference.
  function automatic logic [MW-1:0] tab_val(input int j);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] prod;
    x    = (PI_Q60 * 128'(2 * j + 1)) >>> PAW;
    x2   = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 60) / 128'(2 * n * (2 * n + 1));
      sum  = sum + term;
    end
    prod = sum * 128'(AMP) + (128'sd1 <<< 59);
    return MW'(prod >>> 60);
  endfunction

  logic [MW-1:0] rom [N];
  for (genvar j = 0; j < N; j++) begin : g_rom
    localparam logic [MW-1:0] TV = tab_val(j);
    assign rom[j] = TV;
  end

  logic [FREQ_DW-1:0]      acc_q, acc_d;
  logic [PAW-1:0]          k_q, k_d;
  logic [MW-1:0]           mag_s_q, mag_s_d, mag_c_q, mag_c_d;
  logic                    neg_s_q, neg_s_d, neg_c_q, neg_c_d;
  logic signed [LC_DW-1:0] sin_q, sin_d, cos_q, cos_d;
  logic [PAW-1:0]          kc;

  always_comb begin
    acc_d = acc_q + freq;
    k_d   = PAW'((acc_q + phase) >> (FREQ_DW - PAW));
    kc    = k_q + PAW'(N);
    // Odd quadrants walk the quarter table backwards; upper half negates.
    mag_s_d = rom[k_q[PAW-2] ? ~k_q[QW-1:0] : k_q[QW-1:0]];
    neg_s_d = k_q[PAW-1];
    mag_c_d = rom[kc[PAW-2] ? ~kc[QW-1:0] : kc[QW-1:0]];
    neg_c_d = kc[PAW-1];
    sin_d   = neg_s_q ? -{1'b0, mag_s_q} : {1'b0, mag_s_q};
    cos_d   = neg_c_q ? -{1'b0, mag_c_q} : {1'b0, mag_c_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      k_q     <= '0;
      mag_s_q <= '0;
      mag_c_q <= '0;
      neg_s_q <= 1'b0;
      neg_c_q <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else if (en) begin
      acc_q   <= acc_d;
      k_q     <= k_d;
      mag_s_q <= mag_s_d;
      mag_c_q <= mag_c_d;
      neg_s_q <= neg_s_d;
      neg_c_q <= neg_c_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

  assign sin = sin_q;
  assign cos = cos_q;
endmodule

// File: tb/tb_orth_dds.sv
// Bench for orth_dds: closed-form sin/cos reference with a 3-edge delay, plus literal anchors.
module tb_orth_dds;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst, en;
  logic [31:0] freq, phase;
  logic signed [11:0] sin_o, cos_o;

  int total = 0;
  int bad = 0;

  orth_dds #(.FREQ_DW(32), .LC_DW(12), .PAW(13)) dut (
    .clk(clk), .rst(rst), .en(en), .freq(freq), .phase(phase), .sin(sin_o), .cos(cos_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(-v + 0.5));
  endfunction

  function automatic int ref_sin(input int k);
    return rnd(2047.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 8192.0));
  endfunction

  function automatic int ref_cos(input int k);
    return rnd(2047.0 * $cos(2.0 * PI * (real'(k) + 0.5) / 8192.0));
  endfunction

  // Reference: phase-sum samples delayed by three enabled edges since reset.
  logic [31:0] macc, psum;
  int n_en, v1s, v1c, v2s, v2c, exp_s, exp_c;
  bit started = 0, rst_edge = 0, exp_valid = 0, sweep_on = 0;

  always @(posedge clk) begin
    started = 1;
    rst_edge = rst;
    if (rst) begin
      macc = 0;
      n_en = 0;
      exp_valid = 0;
    end else if (en) begin
      psum = macc + phase;
      exp_s = v2s;
      exp_c = v2c;
      v2s = v1s;
      v2c = v1c;
      v1s = ref_sin(int'(psum[31:19]));
      v1c = ref_cos(int'(psum[31:19]));
      macc = macc + freq;
      n_en++;
      exp_valid = (n_en >= 3);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (rst_edge) begin
        chk("rst_sin", sin_o, 0);
        chk("rst_cos", cos_o, 0);
      end else if (exp_valid) begin
        chk("model_sin", sin_o, exp_s);
        chk("model_cos", cos_o, exp_c);
        if (sweep_on) begin
          int m;
          m = int'(sin_o) * int'(sin_o) + int'(cos_o) * int'(cos_o);
          total++;
          if (m < 2045 * 2045 || m > 2049 * 2049) begin
            bad++;
            $display("FAIL sweep_mag: got %0d want within [%0d,%0d]", m, 2045 * 2045, 2049 * 2049);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s_arr [20];
  int c_arr [20];
  int ns_arr [20];
  int nc_arr [20];

  initial begin
    rst = 1'b1; en = 1'b1; freq = 0; phase = 0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("dc_sin", sin_o, 1);
    chk("dc_cos", cos_o, 2047);
    repeat (3) tick();
    chk("dc_hold_sin", sin_o, 1);

    phase = 32'h4000_0000;
    repeat (3) tick();
    chk("q1_sin", sin_o, 2047);
    chk("q1_cos", cos_o, -1);
    repeat (2) tick();
    phase = 32'h8000_0000;
    repeat (3) tick();
    chk("q2_sin", sin_o, -1);
    chk("q2_cos", cos_o, -2047);

    // Tone at f_clk/16.
    rst = 1'b1; phase = 0; freq = 32'h1000_0000;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    for (int n = 0; n < 20; n++) begin
      tick();
      s_arr[n] = sin_o;
      c_arr[n] = cos_o;
    end
    chk("tone_s0", s_arr[0], 1);
    chk("tone_s4", s_arr[4], 2047);
    chk("tone_s8", s_arr[8], -1);
    chk("tone_s12", s_arr[12], -2047);
    for (int n = 0; n < 4; n++) begin
      chk("tone_period", s_arr[n + 16], s_arr[n]);
      chk("tone_quad", c_arr[n], s_arr[n + 4]);
    end

    en = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("freeze_sin", sin_o, s_arr[19]);
      chk("freeze_cos", cos_o, c_arr[19]);
    end
    en = 1'b1;
    tick();
    chk("resume_sin", sin_o, 2047);
    chk("resume_cos", cos_o, -1);

    // Negative frequency runs the same table backwards.
    rst = 1'b1; freq = 32'hF000_0000;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    for (int n = 0; n < 20; n++) begin
      tick();
      ns_arr[n] = sin_o;
      nc_arr[n] = cos_o;
    end
    chk("neg_s0", ns_arr[0], 1);
    chk("neg_s4", ns_arr[4], -2047);
    chk("neg_wrap", ns_arr[16], 1);
    for (int n = 1; n < 16; n++) begin
      chk("neg_rev_sin", ns_arr[n], s_arr[16 - n]);
      chk("neg_rev_cos", nc_arr[n], c_arr[16 - n]);
    end

    // Linear sweep 1 MHz .. 50 MHz at f_clk = 100 MHz.
    rst = 1'b1; freq = 32'd42949673; phase = 32'h1234_5678;
    tick();
    rst = 1'b0;
    sweep_on = 1;
    for (int i = 0; i < 300; i++) begin
      longint f0, f1;
      f0 = 64'd42949673;
      f1 = 64'd2147483648;
      freq = 32'(f0 + (f1 - f0) * i / 299);
      tick();
    end
    repeat (4) tick();
    sweep_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
